// File: rtl/learner_norm_unit.sv
`default_nettype none
// ============================================================================
// Module   : learner_norm_unit
// Purpose  : Perceptron learning datapath. N combinational learner lanes
//            produce updated sign-magnitude weights; a sequential engine
//            computes floor(sqrt(sum of squared weight magnitudes)) of a
//            weight vector captured at start.
// Revision : 1.0 - initial release
// ============================================================================
module learner_norm_unit #(
    parameter int N      = 20,
    parameter int W      = 9,
    parameter int NORM_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    weights_in,
    input  logic [N-1:0]      neurons,
    input  logic              x_in,
    output logic [N*W-1:0]    wneu_out,
    input  logic              norm_start,
    output logic              norm_busy,
    output logic              norm_done,
    output logic [NORM_W-1:0] norm_out
);

    localparam int c_mag_w = W - 1;
    localparam int c_sq_w  = 2 * c_mag_w;
    // Radicand width is two bits per result bit; the sum of N squares of
    // 8-bit magnitudes stays below 2^21, so the top bit is always zero.
    localparam int c_acc_w = 2 * NORM_W;
    // Remainder carries two extra bits for the shift-in of each bit pair.
    localparam int c_rem_w = NORM_W + 3;
    localparam int c_idx_w = $clog2((N > NORM_W) ? N : NORM_W);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_SQRT = 2'd2;

    // ------------------------------------------------------------------
    // Learner lanes: saturating +/-1 update on the signed value, with the
    // result always re-encoded so that zero is emitted as +0.
    // ------------------------------------------------------------------
    localparam logic signed [W:0] c_one     = (W+1)'(1);
    localparam logic signed [W:0] c_mag_max = (W+1)'((1 << c_mag_w) - 1);

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic        [W-1:0] w_old;
        logic signed [W:0]   w_val;
        logic signed [W:0]   w_delta;
        logic signed [W:0]   w_sum;
        logic signed [W:0]   w_sat;

        assign w_old   = weights_in[j*W +: W];
        assign w_val   = w_old[W-1] ? -$signed({2'b00, w_old[W-2:0]})
                                    :  $signed({2'b00, w_old[W-2:0]});
        assign w_delta = neurons[j] ? (x_in ? c_one : -c_one) : '0;
        assign w_sum   = w_val + w_delta;
        assign w_sat   = (w_sum > c_mag_max)  ? c_mag_max :
                         (w_sum < -c_mag_max) ? -c_mag_max : w_sum;
        assign wneu_out[j*W +: W] =
            {w_sat[W], c_mag_w'(w_sat[W] ? -w_sat : w_sat)};
    end

    // ------------------------------------------------------------------
    // Norm engine
    // ------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [c_mag_w-1:0]   r_mag [N];
    logic [c_acc_w-1:0]   r_acc;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_rem_w-1:0]   r_rem;
    logic [NORM_W-1:0]    r_root;
    logic [NORM_W-1:0]    r_norm;
    logic                 r_done;
    logic                 r_busy;

    logic [c_sq_w-1:0]    w_sq;
    logic [c_acc_w-1:0]   w_acc_sum;
    logic                 w_acc_last;
    logic                 w_sqrt_last;
    logic [c_rem_w-1:0]   w_rem_sh;
    logic [c_rem_w-1:0]   w_trial;
    logic                 w_ge;
    logic [c_rem_w-1:0]   w_rem_next;
    logic [NORM_W-1:0]    w_root_next;

    assign w_sq      = {{c_mag_w{1'b0}}, r_mag[r_idx]} * {{c_mag_w{1'b0}}, r_mag[r_idx]};
    assign w_acc_sum = r_acc + c_acc_w'(w_sq);
    assign w_acc_last  = (r_idx == c_idx_w'(N - 1));
    assign w_sqrt_last = (r_idx == '0);

    // Restoring square root step: bring down the next radicand bit pair and
    // try subtracting (4*root + 1).
    assign w_rem_sh    = (r_rem << 2) | c_rem_w'(r_acc[c_acc_w-1 -: 2]);
    assign w_trial     = c_rem_w'({r_root, 2'b01});
    assign w_ge        = (w_rem_sh >= w_trial);
    assign w_rem_next  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_next = {r_root[NORM_W-2:0], w_ge};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic; start is only honoured while idle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (norm_start)  w_state_next = c_ACC;
            c_ACC:   if (w_acc_last)  w_state_next = c_SQRT;
            c_SQRT:  if (w_sqrt_last) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Magnitude snapshot taken at start so weights_in may change mid-run
    always_ff @(posedge clk) begin
        if (r_state == c_IDLE && norm_start) begin
            for (int k = 0; k < N; k++) r_mag[k] <= weights_in[k*W +: c_mag_w];
        end
    end

    // Accumulate / square-root datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_idx  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_norm <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_state_next != c_IDLE);
            case (r_state)
                c_IDLE: begin
                    if (norm_start) begin
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                c_ACC: begin
                    r_acc <= w_acc_sum;
                    if (w_acc_last) begin
                        r_idx  <= c_idx_w'(NORM_W - 1);
                        r_rem  <= '0;
                        r_root <= '0;
                    end else begin
                        r_idx <= r_idx + c_idx_w'(1);
                    end
                end
                c_SQRT: begin
                    r_acc  <= {r_acc[c_acc_w-3:0], 2'b00};
                    r_rem  <= w_rem_next;
                    r_root <= w_root_next;
                    r_idx  <= r_idx - c_idx_w'(1);
                    if (w_sqrt_last) begin
                        r_norm <= w_root_next;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign norm_busy = r_busy;
    assign norm_done = r_done;
    assign norm_out  = r_norm;

endmodule
`default_nettype wire

// File: tb/tb_learner_norm_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_learner_norm_unit
// Purpose  : Directed self-checking bench for learner_norm_unit with a
//            scoreboard queue of expected norm results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_learner_norm_unit;

    localparam int N  = 20;
    localparam int W  = 9;
    localparam int NW = 11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*W-1:0]  weights_in;
    logic [N-1:0]    neurons;
    logic            x_in;
    logic [N*W-1:0]  wneu_out;
    logic            norm_start;
    logic            norm_busy;
    logic            norm_done;
    logic [NW-1:0]   norm_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [NW-1:0] sb[$];

    always #5 clk = ~clk;

    learner_norm_unit #(.N(N), .W(W), .NORM_W(NW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .weights_in (weights_in),
        .neurons    (neurons),
        .x_in       (x_in),
        .wneu_out   (wneu_out),
        .norm_start (norm_start),
        .norm_busy  (norm_busy),
        .norm_done  (norm_done),
        .norm_out   (norm_out)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sign-magnitude reference for one lane, written case by case
    function automatic logic [W-1:0] lane_model(input logic [W-1:0] w, input logic n, input logic x);
        logic       s;
        logic [7:0] m;
        s = w[8];
        m = w[7:0];
        if (m == 8'd0) s = 1'b0;
        if (n) begin
            if (x) begin
                if (s) begin
                    m = m - 8'd1;
                    if (m == 8'd0) s = 1'b0;
                end else if (m != 8'd255) begin
                    m = m + 8'd1;
                end
            end else begin
                if (!s && m != 8'd0) begin
                    m = m - 8'd1;
                end else begin
                    s = 1'b1;
                    if (m != 8'd255) m = m + 8'd1;
                end
            end
        end
        return {s, m};
    endfunction

    function automatic logic [N*W-1:0] vec_model(input logic [N*W-1:0] w, input logic [N-1:0] n, input logic x);
        logic [N*W-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) r[j*W +: W] = lane_model(w[j*W +: W], n[j], x);
        return r;
    endfunction

    function automatic logic [NW-1:0] norm_model(input logic [N*W-1:0] w);
        int unsigned s;
        int unsigned r;
        int unsigned m;
        s = 0;
        r = 0;
        for (int j = 0; j < N; j++) begin
            m = int'(w[j*W +: 8]);
            s = s + m * m;
        end
        while ((r + 1) * (r + 1) <= s) r++;
        return NW'(r);
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        return (N*W)'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    // Start a norm run, optionally hammering start and weights while busy,
    // and score the result when done appears.
    task automatic run_norm(input string tag, input logic [N*W-1:0] w, input bit spam,
                            output int lat, output int busy_hi);
        bit found;
        weights_in = w;
        norm_start = 1'b1;
        sb.push_back(norm_model(w));
        tick();
        norm_start = 1'b0;
        lat = 0;
        busy_hi = 0;
        found = 1'b0;
        while (!found && lat < 40) begin
            if (norm_busy) busy_hi++;
            if (spam) begin
                norm_start = 1'($urandom_range(0, 1));
                weights_in = rand_vec();
            end
            tick();
            lat++;
            if (norm_done) found = 1'b1;
        end
        norm_start = 1'b0;
        weights_in = w;
        check({tag, "_done_seen"}, (N*W)'(norm_done), (N*W)'(1));
        if (found) check({tag, "_norm_out"}, (N*W)'(norm_out), (N*W)'(sb.pop_front()));
        else void'(sb.pop_front());
        check({tag, "_busy_after_done"}, (N*W)'(norm_busy), (N*W)'(0));
    endtask

    logic [W-1:0]   lt_w   [5] = '{9'h005, 9'h000, 9'h101, 9'h0FF, 9'h1FF};
    logic           lt_x   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0]   lt_exp [5] = '{9'h004, 9'h101, 9'h000, 9'h0FF, 9'h1FF};

    initial begin
        logic [N*W-1:0] w;
        int lat, busy_hi, dcnt;

        rst_n = 1'b0;
        weights_in = '0;
        neurons = '0;
        x_in = 1'b0;
        norm_start = 1'b0;
        tick();
        tick();
        check("reset_busy", (N*W)'(norm_busy), (N*W)'(0));
        check("reset_done", (N*W)'(norm_done), (N*W)'(0));
        check("reset_norm_out", (N*W)'(norm_out), (N*W)'(0));
        rst_n = 1'b1;
        tick();

        // Learner arithmetic on lane 0
        for (int i = 0; i < 5; i++) begin
            w = rand_vec();
            w[8:0] = lt_w[i];
            weights_in = w;
            neurons = 20'h00001;
            x_in = lt_x[i];
            #1;
            check($sformatf("learn_lane0_%0d", i), (N*W)'(wneu_out[8:0]), (N*W)'(lt_exp[i]));
            check($sformatf("learn_vec_%0d", i), wneu_out, vec_model(w, neurons, x_in));
        end

        // Pass-through with neurons all zero, including -0 inputs
        w = rand_vec();
        w[3*W +: W] = 9'h100;
        w[7*W +: W] = 9'h100;
        w[9*W +: W] = 9'h000;
        weights_in = w;
        neurons = '0;
        x_in = 1'b1;
        #1;
        check("pass_neg_zero", (N*W)'(wneu_out[3*W +: W]), (N*W)'(0));
        check("pass_vec", wneu_out, vec_model(w, neurons, x_in));

        // Random independent lanes
        for (int i = 0; i < 4; i++) begin
            weights_in = rand_vec();
            weights_in[2*W +: W] = 9'h100;
            neurons = N'($urandom);
            x_in = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("learn_rand_%0d", i), wneu_out, vec_model(weights_in, neurons, x_in));
        end
        neurons = '0;
        tick();

        // Small norm: +3, -4 -> 5
        w = '0;
        w[0*W +: W] = 9'h003;
        w[1*W +: W] = 9'h104;
        run_norm("small", w, 1'b0, lat, busy_hi);
        check("small_latency", (N*W)'(lat), (N*W)'(31));
        check("small_busy_cycles", (N*W)'(busy_hi), (N*W)'(31));
        check("small_value", (N*W)'(norm_out), (N*W)'(5));
        tick();
        check("small_done_one_cycle", (N*W)'(norm_done), (N*W)'(0));

        // All zero, with some -0 entries
        w = '0;
        w[5*W +: W] = 9'h100;
        w[19*W +: W] = 9'h100;
        run_norm("zero", w, 1'b0, lat, busy_hi);
        check("zero_value", (N*W)'(norm_out), (N*W)'(0));

        // Maximum magnitudes with mixed signs
        for (int j = 0; j < N; j++) w[j*W +: W] = {1'(j % 2), 8'hFF};
        run_norm("max", w, 1'b0, lat, busy_hi);
        check("max_value", (N*W)'(norm_out), (N*W)'(1140));
        check("max_latency", (N*W)'(lat), (N*W)'(31));

        // Reset at cycle 10 of a run aborts with no done pulse
        w = '0;
        w[0*W +: W] = 9'h003;
        w[1*W +: W] = 9'h104;
        weights_in = w;
        norm_start = 1'b1;
        sb.push_back(norm_model(w));
        tick();
        norm_start = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        void'(sb.pop_back());
        check("abort_busy", (N*W)'(norm_busy), (N*W)'(0));
        check("abort_norm_out", (N*W)'(norm_out), (N*W)'(0));
        dcnt = 0;
        repeat (40) begin
            tick();
            if (norm_done) dcnt++;
        end
        check("abort_no_done", (N*W)'(dcnt), (N*W)'(0));

        // Subsequent start computes normally: 6, -8 -> 10
        w = '0;
        w[4*W +: W] = 9'h006;
        w[11*W +: W] = 9'h108;
        run_norm("after_abort", w, 1'b0, lat, busy_hi);
        check("after_abort_value", (N*W)'(norm_out), (N*W)'(10));

        // Start spammed and weights changed while busy
        w = rand_vec();
        run_norm("robust", w, 1'b1, lat, busy_hi);
        check("robust_latency", (N*W)'(lat), (N*W)'(31));
        dcnt = 0;
        repeat (35) begin
            tick();
            if (norm_done) dcnt++;
        end
        check("robust_single_done", (N*W)'(dcnt), (N*W)'(0));
        check("robust_idle", (N*W)'(norm_busy), (N*W)'(0));
        check("scoreboard_empty", (N*W)'(sb.size()), (N*W)'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
